// File: rtl/sar_pkg.sv
// sar_pkg: shared state encoding, comparator flag codes and one-hot check for sar_search
package sar_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, DECIDE, FIN} state_t;
  localparam int CMP_LAT_MAX = 3;
  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;
  function automatic logic onehot3(input logic [2:0] f);
    return f == GT || f == EQ || f == LT;
  endfunction
endpackage

// File: rtl/sar_search.sv
// sar_search: MSB-first successive-approximation search against an external comparator
// SAR_EARLY_EXIT_EN: finish as soon as the comparator reports eq on a trial
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CMP_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);
  localparam int PW = $clog2(WIDTH);
`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  state_t state, nxt;
  logic [WIDTH-1:0] acc, acc_n;
  logic [PW-1:0] p;
  logic [1:0] cnt;
  logic [2:0] flags;
  logic ok, keep, hit;
  assign flags = {cmp_gt, cmp_eq, cmp_lt};
  assign ok = onehot3(flags);
  assign keep = ok && (cmp_gt || cmp_eq);
  assign hit = EARLY && flags == EQ;
  // a kept bit means the trial itself becomes the new accumulator
  assign acc_n = keep ? trial : acc;
  assign busy = state inside {LOAD, WAIT, DECIDE};
  assign done = state == FIN;
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = CMP_LAT > 0 ? WAIT : DECIDE;
      WAIT:    nxt = cnt == 2'd0 ? DECIDE : WAIT;
      DECIDE:  nxt = (!ok || hit || p == '0) ? FIN : LOAD;
      default: nxt = IDLE;
    endcase
  end
  // result is captured on the way into FIN so it is valid alongside done
  always_ff @(posedge clk) begin
    if (rst) begin
      trial  <= '0;
      acc    <= '0;
      p      <= '0;
      cnt    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc    <= '0;
          p      <= PW'(WIDTH - 1);
          result <= '0;
          err    <= 1'b0;
        end
        LOAD: begin
          trial <= acc | (WIDTH'(1) << p);
          cnt   <= 2'(CMP_LAT - 1);
        end
        WAIT: cnt <= cnt - 2'd1;
        DECIDE: begin
          acc <= acc_n;
          p   <= p - 1'b1;
          err <= !ok;
          if (nxt == FIN) result <= acc_n;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: directed vector bench for sar_search with a behavioural comparator
module comparator_nbit #(
  parameter int WIDTH = 4,
  parameter int CMP_LAT = 0
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);
  logic [2:0] f;
  assign f = {a > b, a == b, a < b};
  if (CMP_LAT == 0) begin : g_comb
    assign {gt, eq, lt} = f;
  end else begin : g_pipe
    logic [3*CMP_LAT-1:0] sr;
    always_ff @(posedge clk) sr <= (3*CMP_LAT)'({sr, f});
    assign {gt, eq, lt} = sr[3*CMP_LAT-1 -: 3];
  end
endmodule

module tb_sar_search;
  typedef struct {
    int lat;
    logic [3:0] tgt;
    int inj;
    int pulse;
    logic [0:3][3:0] tr;
    int cyc;
    logic [3:0] res;
    logic er;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start0, start2, ovr_en, sel2;
  logic [3:0] tgt0, tgt2, trial0, trial2, result0, result2, trial_s, result_s;
  logic g0, e0, l0, g2, e2, l2;
  logic busy0, busy2, done0, done2, err0, err2, busy_s, done_s, err_s;
  int nv = 0, nf = 0;
  vec_t vs[10];

  always #5 clk = ~clk;

  comparator_nbit #(.WIDTH(4), .CMP_LAT(0)) cmp0 (.clk(clk), .a(tgt0), .b(trial0), .gt(g0), .eq(e0), .lt(l0));
  comparator_nbit #(.WIDTH(4), .CMP_LAT(2)) cmp2 (.clk(clk), .a(tgt2), .b(trial2), .gt(g2), .eq(e2), .lt(l2));

  sar_search #(.WIDTH(4), .CMP_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .cmp_gt(g0 | ovr_en), .cmp_eq(e0 | ovr_en), .cmp_lt(l0 & ~ovr_en),
    .trial(trial0), .busy(busy0), .done(done0), .result(result0), .err(err0));
  sar_search #(.WIDTH(4), .CMP_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .cmp_gt(g2), .cmp_eq(e2), .cmp_lt(l2),
    .trial(trial2), .busy(busy2), .done(done2), .result(result2), .err(err2));

  assign trial_s  = sel2 ? trial2 : trial0;
  assign result_s = sel2 ? result2 : result0;
  assign busy_s   = sel2 ? busy2 : busy0;
  assign done_s   = sel2 ? done2 : done0;
  assign err_s    = sel2 ? err2 : err0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nv++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int lat, int tgt, int inj, int pulse, logic [15:0] tr, int cyc, int res, logic er);
    vec_t v;
    v.lat = lat; v.tgt = 4'(tgt); v.inj = inj; v.pulse = pulse;
    v.tr = tr; v.cyc = cyc; v.res = 4'(res); v.er = er;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input vec_t v);
    int c;
    sel2 = v.lat == 2;
    tgt0 = v.tgt;
    tgt2 = v.tgt;
    if (sel2) start2 = 1'b1; else start0 = 1'b1;
    for (c = 1; c <= 40; c++) begin
      step();
      start0 = c == v.pulse;
      start2 = 1'b0;
      ovr_en = c == v.inj;
      if (done_s) break;
      chk("busy", 32'(busy_s), 1);
      if (c >= 2) chk($sformatf("trial@%0d", c), 32'(trial_s), 32'(v.tr[((c - 2) / (v.lat + 2)) & 3]));
    end
    ovr_en = 1'b0;
    start0 = 1'b0;
    chk($sformatf("latency T=%0d", v.tgt), c, v.cyc);
    chk($sformatf("result T=%0d", v.tgt), 32'(result_s), 32'(v.res));
    chk("err", 32'(err_s), 32'(v.er));
    chk("busy_fin", 32'(busy_s), 0);
    step();
    chk("done_pulse", 32'(done_s), 0);
    chk("result_held", 32'(result_s), 32'(v.res));
    chk("err_held", 32'(err_s), 32'(v.er));
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0; ovr_en = 1'b0; sel2 = 1'b0;
    tgt0 = '0; tgt2 = '0;
`ifdef SAR_EARLY_EXIT_EN
    vs[1] = mk(0, 8, 0, 0, {4'd8, 4'd0, 4'd0, 4'd0}, 3, 8, 0);
    vs[5] = mk(0, 6, 0, 0, {4'd8, 4'd4, 4'd6, 4'd0}, 7, 6, 0);
    vs[7] = mk(2, 10, 0, 0, {4'd8, 4'd12, 4'd10, 4'd0}, 13, 10, 0);
`else
    vs[1] = mk(0, 8, 0, 0, {4'd8, 4'd12, 4'd10, 4'd9}, 9, 8, 0);
    vs[5] = mk(0, 6, 0, 0, {4'd8, 4'd4, 4'd6, 4'd7}, 9, 6, 0);
    vs[7] = mk(2, 10, 0, 0, {4'd8, 4'd12, 4'd10, 4'd11}, 17, 10, 0);
`endif
    vs[0] = mk(0, 9, 0, 0, {4'd8, 4'd12, 4'd10, 4'd9}, 9, 9, 0);
    vs[2] = mk(0, 0, 0, 0, {4'd8, 4'd4, 4'd2, 4'd1}, 9, 0, 0);
    vs[3] = mk(0, 15, 0, 0, {4'd8, 4'd12, 4'd14, 4'd15}, 9, 15, 0);
    vs[4] = mk(0, 9, 4, 0, {4'd8, 4'd12, 4'd0, 4'd0}, 5, 8, 1);
    vs[6] = mk(2, 5, 0, 0, {4'd8, 4'd4, 4'd6, 4'd5}, 17, 5, 0);
    vs[8] = mk(0, 9, 0, 4, {4'd8, 4'd12, 4'd10, 4'd9}, 9, 9, 0);
    vs[9] = mk(0, 3, 0, 0, {4'd8, 4'd4, 4'd2, 4'd3}, 9, 3, 0);
    step();
    step();
    chk("rst trial0", 32'(trial0), 0);
    chk("rst busy0", 32'(busy0), 0);
    chk("rst done0", 32'(done0), 0);
    chk("rst result0", 32'(result0), 0);
    chk("rst err0", 32'(err0), 0);
    chk("rst trial2", 32'(trial2), 0);
    chk("rst busy2", 32'(busy2), 0);
    chk("rst done2", 32'(done2), 0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 9; i++) begin
      run(vs[i]);
      step();
    end
    // abort a search with reset in its fourth cycle
    sel2 = 1'b0;
    tgt0 = 4'd12;
    start0 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      start0 = 1'b0;
    end
    chk("pre_rst trial", 32'(trial0), 8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort trial", 32'(trial0), 0);
    chk("abort busy", 32'(busy0), 0);
    chk("abort done", 32'(done0), 0);
    chk("abort result", 32'(result0), 0);
    chk("abort err", 32'(err0), 0);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      seen |= done0 | busy0;
    end
    chk("abort no_done", 32'(seen), 0);
    run(vs[9]);
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule
